// File: rtl/cache_port_arbiter_if.sv
// Bundles both requester handshakes and the shared memory port.
// The arbiter connects through 'slave'; requesters and storage connect through 'master'.
interface cache_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_we;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_we;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  req0_valid, req0_addr, req0_wdata, req0_we,
    input  req1_valid, req1_addr, req1_wdata, req1_we,
    input  mem_rdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output req0_valid, req0_addr, req0_wdata, req0_we,
    output req1_valid, req1_addr, req1_wdata, req1_we,
    output mem_rdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Two-requester round-robin arbiter that sequences one access at a time onto a
// single-port storage array with a fixed read latency.
module cache_port_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  id_q, id_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [3:0]            cnt_q, cnt_d;

  logic grant;
  logic idle;
  logic accept;

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end
  end

  assign idle           = (state_q == IDLE);
  assign bus.req0_ready = rst && idle && bus.req0_valid && !grant;
  assign bus.req1_ready = rst && idle && bus.req1_valid && grant;
  assign accept         = bus.req0_ready || bus.req1_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d         = grant;
          last_grant_d = grant;
          addr_d       = grant ? bus.req1_addr  : bus.req0_addr;
          wdata_d      = grant ? bus.req1_wdata : bus.req0_wdata;
          we_d         = grant ? bus.req1_we    : bus.req0_we;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Read data lands in the cycle the counter reaches zero.
        if (cnt_q == 4'd0) begin
          if (id_q) begin
            rdata1_d = bus.mem_rdata;
          end else begin
            rdata0_d = bus.mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.mem_en     = (state_q == ISSUE);
  assign bus.mem_we     = (state_q == ISSUE) && we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.rsp0_valid = (state_q == RESP) && !id_q;
  assign bus.rsp1_valid = (state_q == RESP) && id_q;
  assign bus.rsp0_rdata = rdata0_q;
  assign bus.rsp1_rdata = rdata1_q;
  assign bus.busy       = !idle;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: a latency-2 instance driven by both
// requesters and a latency-1 instance for the short-pipeline build.
module tb_cache_port_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int LAT  = 2;
  localparam int LAT1 = 1;

  typedef struct {
    int          port;
    logic [DW-1:0] rdata;
    int          cyc;
  } rsp_exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } mem_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int compared   = 0;
  int mismatched = 0;

  rsp_exp_t rspQ[$];
  mem_exp_t memQ[$];
  rsp_exp_t rsp1Q[$];
  int       grantLog[$];
  int       hsCyc[$];
  logic [DW-1:0] expLast [2];

  logic [DW-1:0] mem  [256];
  logic [DW-1:0] pipe [LAT];
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] pipe1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
  cache_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  cache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  cache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Storage models: writes land at the edge, reads appear LAT cycles after mem_en.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    pipe[0] <= mem[bus.mem_addr];
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.mem_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    pipe1 <= mem1[bus1.mem_addr];
  end
  assign bus1.mem_rdata = pipe1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void setReq(input int port, input logic v, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic w);
    if (port == 0) begin
      bus.req0_valid = v; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_we = w;
    end else begin
      bus.req1_valid = v; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_we = w;
    end
  endfunction

  // Holds the request until accepted, then queues the expected memory strobe and response.
  task automatic applyStimulus(input int port, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic we, input logic [DW-1:0] expRdata, input bit expectRsp);
    bit done = 0;
    setReq(port, 1'b1, addr, wdata, we);
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if ((port == 0 ? bus.req0_ready : bus.req1_ready) === 1'b1) begin
        done = 1;
        hsCyc.push_back(cyc);
        grantLog.push_back(port);
        memQ.push_back(mem_exp_t'{we, addr, wdata, cyc + 1});
        if (expectRsp) begin
          if (!we) expLast[port] = expRdata;
          rspQ.push_back(rsp_exp_t'{port, expLast[port], cyc + (we ? 2 : 2 + LAT)});
        end
        @(posedge clk);
        #1;
        setReq(port, 1'b0, addr, wdata, we);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checkOutput($sformatf("accept timeout port %0d", port), 32'd0, 32'd1);
      setReq(port, 1'b0, addr, wdata, we);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rspQ.size() != 0 || memQ.size() != 0 || rsp1Q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard drained", 32'(rspQ.size() + memQ.size() + rsp1Q.size()), 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    rsp_exp_t r;
    mem_exp_t m;
    if (rst) begin
      if (bus.mem_en) begin
        if (memQ.size() == 0) begin
          checkOutput("unexpected mem_en", 32'd1, 32'd0);
        end else begin
          m = memQ.pop_front();
          checkOutput("mem_en cycle", 32'(cyc), 32'(m.cyc));
          checkOutput("mem_we", 32'(bus.mem_we), 32'(m.we));
          checkOutput("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
          checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(m.wdata));
        end
      end
      if (bus.rsp0_valid && bus.rsp1_valid) begin
        checkOutput("rsp on both ports", 32'd1, 32'd0);
      end else if (bus.rsp0_valid || bus.rsp1_valid) begin
        if (rspQ.size() == 0) begin
          checkOutput("unexpected rsp", 32'd1, 32'd0);
        end else begin
          r = rspQ.pop_front();
          checkOutput("rsp port", 32'(bus.rsp1_valid ? 1 : 0), 32'(r.port));
          checkOutput("rsp cycle", 32'(cyc), 32'(r.cyc));
          checkOutput("rsp rdata", 32'(bus.rsp1_valid ? bus.rsp1_rdata : bus.rsp0_rdata), 32'(r.rdata));
        end
      end
      if (bus1.rsp0_valid || bus1.rsp1_valid) begin
        if (rsp1Q.size() == 0) begin
          checkOutput("unexpected rsp lat1", 32'd1, 32'd0);
        end else begin
          r = rsp1Q.pop_front();
          checkOutput("lat1 rsp port", 32'(bus1.rsp1_valid ? 1 : 0), 32'(r.port));
          checkOutput("lat1 rsp cycle", 32'(cyc), 32'(r.cyc));
          checkOutput("lat1 rsp rdata", 32'(bus1.rsp0_rdata), 32'(r.rdata));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int expGrant [4];
    expGrant = '{0, 1, 0, 1};
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'h00;
      mem1[i] = 8'h00;
    end
    mem[8'h12] = 8'hA5; mem[8'h13] = 8'h11; mem[8'h20] = 8'h22; mem[8'h21] = 8'h33;
    mem[8'h50] = 8'h61; mem[8'h51] = 8'h62; mem[8'h52] = 8'h63;
    mem1[8'h08] = 8'h7E;
    expLast[0] = '0;
    expLast[1] = '0;
    setReq(0, 1'b0, '0, '0, 1'b0);
    setReq(1, 1'b0, '0, '0, 1'b0);
    bus1.req0_valid = 0; bus1.req0_addr = '0; bus1.req0_wdata = '0; bus1.req0_we = 0;
    bus1.req1_valid = 0; bus1.req1_addr = '0; bus1.req1_wdata = '0; bus1.req1_we = 0;

    // Reset state, with a request already pending.
    repeat (3) @(negedge clk);
    bus.req0_valid = 1'b1;
    #1;
    checkOutput("reset req0_ready", 32'(bus.req0_ready), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset mem_en", 32'(bus.mem_en), 32'd0);
    checkOutput("reset rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    checkOutput("reset rsp0_rdata", 32'(bus.rsp0_rdata), 32'd0);
    checkOutput("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Both requesters held valid out of reset: strict alternation starting at 0.
    grantLog.delete();
    fork
      begin
        applyStimulus(0, 8'h12, 8'h00, 1'b0, 8'hA5, 1);
        applyStimulus(0, 8'h13, 8'h00, 1'b0, 8'h11, 1);
      end
      begin
        applyStimulus(1, 8'h20, 8'h00, 1'b0, 8'h22, 1);
        applyStimulus(1, 8'h21, 8'h00, 1'b0, 8'h33, 1);
      end
    join
    drain();
    checkOutput("tie grant count", 32'(grantLog.size()), 32'd4);
    for (int i = 0; i < 4 && i < grantLog.size(); i++)
      checkOutput($sformatf("tie grant %0d", i), 32'(grantLog[i]), 32'(expGrant[i]));

    // Single read and write-then-read on requester 1.
    applyStimulus(0, 8'h12, 8'h00, 1'b0, 8'hA5, 1);
    drain();
    applyStimulus(1, 8'h40, 8'h3C, 1'b1, 8'h00, 1);
    drain();
    applyStimulus(1, 8'h40, 8'h00, 1'b0, 8'h3C, 1);
    drain();

    // Lone requester back-to-back: a new accept right after each RESP.
    hsCyc.delete();
    grantLog.delete();
    applyStimulus(0, 8'h50, 8'h00, 1'b0, 8'h61, 1);
    applyStimulus(0, 8'h51, 8'h00, 1'b0, 8'h62, 1);
    applyStimulus(0, 8'h52, 8'h00, 1'b0, 8'h63, 1);
    drain();
    checkOutput("lone grant count", 32'(grantLog.size()), 32'd3);
    if (hsCyc.size() == 3) begin
      checkOutput("lone gap 1", 32'(hsCyc[1] - hsCyc[0]), 32'(LAT + 3));
      checkOutput("lone gap 2", 32'(hsCyc[2] - hsCyc[1]), 32'(LAT + 3));
    end
    for (int i = 0; i < grantLog.size(); i++)
      checkOutput($sformatf("lone grant %0d", i), 32'(grantLog[i]), 32'd0);

    // Reset during WAIT drops the read; the next tie still goes to requester 0.
    @(negedge clk);
    applyStimulus(0, 8'h12, 8'h00, 1'b0, 8'hA5, 0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("busy in WAIT", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("mid-reset busy", 32'(bus.busy), 32'd0);
    checkOutput("mid-reset mem_en", 32'(bus.mem_en), 32'd0);
    checkOutput("mid-reset rsp valids", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    checkOutput("mid-reset rsp0_rdata", 32'(bus.rsp0_rdata), 32'd0);
    expLast[0] = '0;
    expLast[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    grantLog.delete();
    fork
      applyStimulus(0, 8'h13, 8'h00, 1'b0, 8'h11, 1);
      applyStimulus(1, 8'h20, 8'h00, 1'b0, 8'h22, 1);
    join
    drain();
    if (grantLog.size() > 0) checkOutput("post-reset first grant", 32'(grantLog[0]), 32'd0);
    else checkOutput("post-reset grant count", 32'd0, 32'd2);

    // Latency-1 build: response three cycles after the handshake.
    @(negedge clk);
    bus1.req0_valid = 1'b1;
    bus1.req0_addr  = 8'h08;
    bus1.req0_we    = 1'b0;
    #1;
    checkOutput("lat1 req0_ready", 32'(bus1.req0_ready), 32'd1);
    rsp1Q.push_back(rsp_exp_t'{0, 8'h7E, cyc + 3});
    @(posedge clk);
    #1;
    bus1.req0_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
